// File: rtl/sram_resp_pkg.sv
// Shared constants for the SRAM responder: FSM encoding, byte-lane width, default window base.
package sram_resp_pkg;
    localparam logic        STATE_CLEAR   = 1'b0;
    localparam logic        STATE_READY   = 1'b1;
    localparam int          BYTE_W        = 8;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h1c00_0000;
endpackage

// File: rtl/sram_bwe_array.sv
// Single-port word array with per-byte write enables and a read-first registered output.
// The output register can be forced to zero synchronously; the array itself is never reset.
module sram_bwe_array
    import sram_resp_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [3:0]        i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic              i_rd_en,
    input  logic              i_rd_zero,
    output logic [31:0]       o_rdata
);
    localparam int DEPTH = 2**ADDR_W;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_we[i]) begin
                    r_mem[i_addr][i*BYTE_W +: BYTE_W] <= i_wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Sampling the array in the same edge as the write yields the pre-write word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_rd_zero) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the core's SRAM-style ports: range check, sticky error, optional
// post-reset zero-fill (enabled by defining SRAM_RESP_CLR_INIT_EN).
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        init_busy,
    output logic        err
);
    logic [ADDR_W-1:0] w_idx;
    logic              w_in_range;
    logic              w_ready;
    logic              w_acc;
    logic              w_arr_wr_en;
    logic [3:0]        w_arr_we;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [31:0]       w_arr_wdata;
    logic              w_rd_en;
    logic              w_rd_zero;
    logic              r_err;
    logic              w_unused_addr_lsb;

    assign w_idx             = sram_addr[ADDR_W+1:2];
    assign w_in_range        = (sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign w_unused_addr_lsb = ^sram_addr[1:0];

`ifdef SRAM_RESP_CLR_INIT_EN
    localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

    logic            r_state;
    logic [ADDR_W:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= STATE_CLEAR;
            r_cnt   <= '0;
        end else if (r_state == STATE_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
                r_state <= STATE_READY;
            end
        end
    end

    assign w_ready   = (r_state == STATE_READY);
    assign init_busy = (r_state == STATE_CLEAR);
    assign w_acc     = w_ready & sram_en;

    // While clearing, the array port belongs to the counter and core requests are dropped.
    always_comb begin
        w_arr_wr_en = w_acc & w_in_range & (|sram_we);
        w_arr_we    = sram_we;
        w_arr_addr  = w_idx;
        w_arr_wdata = sram_wdata;
        if (!w_ready) begin
            w_arr_wr_en = 1'b1;
            w_arr_we    = 4'hf;
            w_arr_addr  = r_cnt[ADDR_W-1:0];
            w_arr_wdata = '0;
        end
    end
`else
    assign w_ready     = 1'b1;
    assign init_busy   = 1'b0;
    assign w_acc       = w_ready & sram_en;
    assign w_arr_wr_en = w_acc & w_in_range & (|sram_we);
    assign w_arr_we    = sram_we;
    assign w_arr_addr  = w_idx;
    assign w_arr_wdata = sram_wdata;
`endif

    assign w_rd_en   = w_acc & w_in_range;
    assign w_rd_zero = w_acc & ~w_in_range;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (w_rd_zero) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    sram_bwe_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk     (clk),
        .i_rst_n   (resetn),
        .i_wr_en   (w_arr_wr_en),
        .i_we      (w_arr_we),
        .i_addr    (w_arr_addr),
        .i_wdata   (w_arr_wdata),
        .i_rd_en   (w_rd_en),
        .i_rd_zero (w_rd_zero),
        .o_rdata   (sram_rdata)
    );
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder at ADDR_W=4; exercises the clear sequence when
// SRAM_RESP_CLR_INIT_EN is defined, otherwise preloads the array with zeros.
module tb_sram_responder;
  localparam int ADDR_W = 4;
  localparam logic [31:0] BASE = 32'h1c00_0000;
  localparam logic [31:0] OOR_ADDR = 32'h1d00_0000;
`ifdef SRAM_RESP_CLR_INIT_EN
  localparam int EXP_CLR = 16;
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam int EXP_CLR = 0;
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        init_busy;
  logic        err;

  int n_total = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  sram_responder #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .init_busy  (init_busy),
    .err        (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wd);
    sram_en    = en;
    sram_we    = we;
    sram_addr  = addr;
    sram_wdata = wd;
  endtask

  task automatic access(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    drive(1'b1, we, addr, wd);
    step();
    sram_en = 1'b0;
  endtask

  // scoreboard: every access queues the word it must return one cycle later
  task automatic acc_chk(input string tag, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp);
    exp_q.push_back(exp);
    access(we, addr, wd);
    check(tag, sram_rdata, exp_q.pop_front());
  endtask

  task automatic junk(input int n);
    if (n % 2 == 0) drive(1'b1, 4'hf, BASE + 32'(4 * (n % 16)), 32'hffff_ffff);
    else drive(1'b1, 4'h0, OOR_ADDR, 32'h0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (init_busy && n < 100) begin
      junk(n);
      step();
      n++;
    end
    sram_en = 1'b0;
  endtask

  int busy_n;

  initial begin
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    resetn = 1'b0;
    step();
    step();
    check("rst_rdata", sram_rdata, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_busy", {31'h0, init_busy}, {31'h0, EXP_BUSY_RST});
    resetn = 1'b1;

`ifdef SRAM_RESP_CLR_INIT_EN
    for (int c = 0; c < 7; c++) begin
      junk(c);
      step();
    end
    check("busy_mid_clear", {31'h0, init_busy}, 32'h1);
    sram_en = 1'b0;
    resetn = 1'b0;
    #1;
    check("busy_in_rst", {31'h0, init_busy}, 32'h1);
    step();
    resetn = 1'b1;
`endif
    count_busy(busy_n);
    check("clear_cycles", 32'(busy_n), 32'(EXP_CLR));
    check("clear_rdata", sram_rdata, 32'h0);
    check("clear_err", {31'h0, err}, 32'h0);

`ifndef SRAM_RESP_CLR_INIT_EN
    for (int i = 0; i < 16; i++) access(4'hf, BASE + 32'(4 * i), 32'h0);
`endif
    for (int i = 0; i < 16; i++) acc_chk($sformatf("zero_rd%0d", i), 4'h0, BASE + 32'(4 * i), 32'h0, 32'h0);

    // full word, then lane-masked write; each write returns the prior word
    acc_chk("wr_full_old", 4'hf, BASE + 32'h8, 32'hdead_beef, 32'h0);
    acc_chk("rd_full", 4'h0, BASE + 32'h8, 32'h0, 32'hdead_beef);
    acc_chk("wr_0101_old", 4'b0101, BASE + 32'h8, 32'h1122_3344, 32'hdead_beef);
    acc_chk("rd_0101", 4'h0, BASE + 32'h8, 32'h0, 32'hde22_be44);

    acc_chk("wr_c", 4'hf, BASE + 32'hc, 32'hdead_beef, 32'h0);
    acc_chk("rd_first", 4'hf, BASE + 32'hc, 32'h0000_0001, 32'hdead_beef);
    acc_chk("rd_after_rf", 4'h0, BASE + 32'hd, 32'h0, 32'h0000_0001);

    acc_chk("wr_10", 4'hf, BASE + 32'h10, 32'haabb_ccdd, 32'h0);
    acc_chk("wr_0011", 4'b0011, BASE + 32'h10, 32'h1122_3344, 32'haabb_ccdd);
    acc_chk("wr_1000", 4'b1000, BASE + 32'h10, 32'h5566_7788, 32'haabb_3344);
    acc_chk("rd_10", 4'h0, BASE + 32'h10, 32'h0, 32'h55bb_3344);

    step();
    step();
    check("idle_hold", sram_rdata, 32'h55bb_3344);
    check("err_before_oor", {31'h0, err}, 32'h0);

    acc_chk("oor_rd", 4'h0, OOR_ADDR, 32'h0, 32'h0);
    check("oor_err", {31'h0, err}, 32'h1);
    acc_chk("oor_wr", 4'hf, BASE + 32'h48, 32'hcafe_f00d, 32'h0);
    acc_chk("oor_no_alias", 4'h0, BASE + 32'h8, 32'h0, 32'hde22_be44);
    acc_chk("valid_after_err", 4'h0, BASE + 32'h3c, 32'h0, 32'h0);
    check("err_sticky", {31'h0, err}, 32'h1);

    // reset during READY
    resetn = 1'b0;
    #1;
    check("rst2_err", {31'h0, err}, 32'h0);
    check("rst2_rdata", sram_rdata, 32'h0);
    step();
    resetn = 1'b1;
    count_busy(busy_n);
    check("clear2_cycles", 32'(busy_n), 32'(EXP_CLR));
    check("clear2_err", {31'h0, err}, 32'h0);
`ifdef SRAM_RESP_CLR_INIT_EN
    acc_chk("rst_ready_8", 4'h0, BASE + 32'h8, 32'h0, 32'h0);
    acc_chk("rst_ready_10", 4'h0, BASE + 32'h10, 32'h0, 32'h0);
`else
    acc_chk("rst_ready_8", 4'h0, BASE + 32'h8, 32'h0, 32'hde22_be44);
    acc_chk("rst_ready_10", 4'h0, BASE + 32'h10, 32'h0, 32'h55bb_3344);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
